// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP test-pattern transmitter: FSM encoding,
// pattern identifiers and the colour-bar palette.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } dvp_state_e;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_FCNT  = 2'd3;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 pixel generator: selects one of four test patterns
// from the pixel position, bar index and frame counter.
module dvp_pattern_gen
    import dvp_pkg::*;
(
    input  logic [1:0]  i_sel,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [2:0]  i_bar,
    input  logic [7:0]  i_frame_cnt,
    output logic [15:0] o_pix
);

    always_comb begin
        o_pix = 16'h0000;
        case (i_sel)
            PAT_BARS:  o_pix = bar_color(i_bar);
            PAT_GRAD:  o_pix = i_x + i_y;
            PAT_CHECK: o_pix = (i_x[4] ^ i_y[4]) ? 16'hFFFF : 16'h0000;
            default:   o_pix = {i_frame_cnt, i_frame_cnt};
        endcase
    end

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP test-pattern transmitter: frame timing FSM with line/clock counters and
// a registered RGB565 byte mux driving vsync, href and data.
module dvp_pattern_tx
    import dvp_pkg::*;
#(
    parameter int H_PIXEL  = 1024,
    parameter int V_PIXEL  = 768,
    parameter int H_BLANK  = 256,
    parameter int VS_LINES = 4,
    parameter int V_BACK   = 16,
    parameter int V_FRONT  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       dvp_vsync,
    output logic       dvp_href,
    output logic [7:0] dvp_data,
    output logic       frame_done
);

    localparam int LINE_CYC = 2 * H_PIXEL + H_BLANK;
    localparam int CW       = $clog2(LINE_CYC);
    localparam int MAX_A    = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int MAX_B    = (V_PIXEL > V_FRONT) ? V_PIXEL : V_FRONT;
    localparam int MAXL     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LW       = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam int BAR_W    = H_PIXEL / 8;
    localparam int BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(LINE_CYC - 1);
    localparam logic [CW-1:0] C_HREF = CW'(2 * H_PIXEL);
    localparam logic [LW-1:0] L_VS   = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] L_VB   = LW'(V_BACK - 1);
    localparam logic [LW-1:0] L_ACT  = LW'(V_PIXEL - 1);
    localparam logic [LW-1:0] L_VF   = LW'(V_FRONT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);

    dvp_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [LW-1:0] r_line;
    logic [2:0]    r_bar;
    logic [BW-1:0] r_bar_pix;
    logic [1:0]    r_sel;
    logic [7:0]    r_frame_cnt;

    dvp_state_e    w_state;
    logic [CW-1:0] w_cnt;
    logic [LW-1:0] w_line;
    logic [LW-1:0] w_last_line;
    logic [2:0]    w_bar;
    logic [BW-1:0] w_bar_pix;
    logic          w_frame_end;
    logic          w_href;
    logic [15:0]   w_pix;

    // Next position in the frame; outputs are registered from this so that
    // they line up with the counters on the same edge.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_line      = r_line;
        w_bar       = r_bar;
        w_bar_pix   = r_bar_pix;
        w_last_line = L_VF;
        case (r_state)
            ST_VSYNC:  w_last_line = L_VS;
            ST_VBACK:  w_last_line = L_VB;
            ST_ACTIVE: w_last_line = L_ACT;
            default:   w_last_line = L_VF;
        endcase
        w_frame_end = (r_state == ST_VFRONT) && (r_cnt == C_LAST) && (r_line == L_VF);

        if (r_state == ST_IDLE) begin
            if (en) begin
                w_state = ST_VSYNC;
                w_cnt   = '0;
                w_line  = '0;
            end
        end else if (r_cnt == C_LAST) begin
            w_cnt = '0;
            if (r_line == w_last_line) begin
                w_line = '0;
                case (r_state)
                    ST_VSYNC:  w_state = ST_VBACK;
                    ST_VBACK:  w_state = ST_ACTIVE;
                    ST_ACTIVE: w_state = ST_VFRONT;
                    default:   w_state = en ? ST_VSYNC : ST_IDLE;
                endcase
            end else begin
                w_line = r_line + 1'b1;
            end
        end else begin
            w_cnt = r_cnt + 1'b1;
        end

        // Bar index advances every BAR_W pixels, tracked by counting pixels
        if (w_cnt == '0) begin
            w_bar     = '0;
            w_bar_pix = '0;
        end else if (!w_cnt[0] && (w_cnt < C_HREF)) begin
            if (r_bar_pix == B_LAST) begin
                w_bar_pix = '0;
                w_bar     = r_bar + 1'b1;
            end else begin
                w_bar_pix = r_bar_pix + 1'b1;
            end
        end

        w_href = (w_state == ST_ACTIVE) && (w_cnt < C_HREF);
    end

    dvp_pattern_gen u_gen (
        .i_sel       (r_sel),
        .i_x         (16'(w_cnt >> 1)),
        .i_y         (16'(w_line)),
        .i_bar       (w_bar),
        .i_frame_cnt (r_frame_cnt),
        .o_pix       (w_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_line      <= '0;
            r_bar       <= '0;
            r_bar_pix   <= '0;
            r_sel       <= '0;
            r_frame_cnt <= '0;
            dvp_vsync   <= 1'b0;
            dvp_href    <= 1'b0;
            dvp_data    <= 8'h00;
            frame_done  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_line    <= w_line;
            r_bar     <= w_bar;
            r_bar_pix <= w_bar_pix;
            if ((w_state == ST_VSYNC) && (r_state != ST_VSYNC))
                r_sel <= pattern_sel;
            if (w_frame_end)
                r_frame_cnt <= r_frame_cnt + 8'd1;
            dvp_vsync  <= (w_state == ST_VSYNC);
            dvp_href   <= w_href;
            dvp_data   <= w_href ? (w_cnt[0] ? w_pix[7:0] : w_pix[15:8]) : 8'h00;
            frame_done <= (w_state == ST_VFRONT) && (w_cnt == C_LAST) && (w_line == L_VF);
        end
    end

endmodule

// File: doc/dvp_pattern_tx.md
DVP_PATTERN_TX -- requirements
Module: dvp_pattern_tx

Interface
REQ-001 Parameter H_PIXEL, 1024: active pixels per line; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter V_PIXEL, 768: active lines per frame.
REQ-003 Parameter H_BLANK, 256: href-low clocks after each line's data.
REQ-004 Parameters VS_LINES 4, V_BACK 16, V_FRONT 8: vsync-high lines, post-vsync blank lines and post-active blank lines.
REQ-005 clk  in  1  byte clock; one DVP byte per cycle; the consumer samples on this clock (cam_pclk equivalent).
REQ-006 rst_n  in  1  asynchronous reset, active low.
REQ-007 en  in  1  level input; frame generation runs while high.
REQ-008 pattern_sel  in  2  test-pattern select: 0 colour bars, 1 gradient, 2 checkerboard, 3 frame counter.
REQ-009 dvp_vsync  out  1  frame sync, active high.
REQ-010 dvp_href  out  1  line valid, active high.
REQ-011 dvp_data  out  8  RGB565 byte stream: high byte first, then low byte.
REQ-012 frame_done  out  1  one-cycle pulse at the end of each frame.

Function
REQ-013 Line period is LINE_CYC = 2*H_PIXEL + H_BLANK clocks; every phase below lasts a whole number of line periods.
REQ-014 FSM states and order: IDLE, VSYNC (VS_LINES lines), VBACK (V_BACK lines), ACTIVE (V_PIXEL lines), VFRONT (V_FRONT lines).
REQ-015 IDLE -> VSYNC on the first clk edge with en=1; dvp_vsync goes to 1 on that same edge.
REQ-016 In VSYNC, dvp_vsync=1 and dvp_href=0; in every other state, dvp_vsync=0.
REQ-017 In each ACTIVE line, dvp_href=1 for clocks 0..2*H_PIXEL-1 and 0 for the remaining H_BLANK clocks.
REQ-018 dvp_data=8'h00 whenever dvp_href=0.
REQ-019 Pixel x (0..H_PIXEL-1) occupies line clocks 2x (high byte) and 2x+1 (low byte); y counts ACTIVE lines from 0.
REQ-020 Pattern 0: 8 equal bars, bar index = x/(H_PIXEL/8), built from a bar counter with no divider; colours in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-021 Pattern 1: pixel = (x + y) mod 2^16.
REQ-022 Pattern 2: pixel = FFFF when x[4] XOR y[4] is 1, else 0000.
REQ-023 Pattern 3: pixel = {frame_cnt[7:0], frame_cnt[7:0]}.
REQ-024 frame_cnt: 8-bit, 0 after reset, increments at every frame_done and wraps 255 -> 0.
REQ-025 pattern_sel is sampled on entry to VSYNC and held for the whole frame; changes mid-frame have no effect on that frame.
REQ-026 frame_done pulses on the last clock of VFRONT.
REQ-027 At the end of VFRONT: if en=1, go to VSYNC with no gap; otherwise go to IDLE.
REQ-028 en deasserted mid-frame SHALL NOT truncate the frame; the current frame always completes.
REQ-029 All outputs are registered, with no combinational path from inputs to outputs.
REQ-030 Counters are sized with $clog2 of their maximum value and SHALL NOT overflow at the default parameters.

Reset
REQ-031 While rst_n=0, the FSM is IDLE and all counters, frame_cnt, dvp_vsync, dvp_href, dvp_data and frame_done are 0.
REQ-032 Reset asserted mid-frame takes effect immediately; after release, the block waits in IDLE for en.

Structure
REQ-033 Pattern-id constants, the 8 bar colours and the FSM state encoding belong in shared package dvp_pkg.
REQ-034 Single sub-module dvp_pattern_gen (combinational pixel from x, y, frame_cnt and the latched pattern) feeds a registered byte mux in the top level.

Verification
Bench parameters: H_PIXEL=8, V_PIXEL=4, H_BLANK=4, VS_LINES=1, V_BACK=1, V_FRONT=1, giving LINE_CYC=20 and 140 clocks per frame.
REQ-035 Timing: en=1 held, sel=0 -> vsync high 20 clocks; first href rises 40 clocks after vsync rises; 4 href pulses of 16 clocks each, 20 clocks apart; frame_done at clock 139; next vsync at clock 140.
REQ-036 Colour bars: sel=0 -> line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00 on every line.
REQ-037 Gradient and frame counter: sel=1 -> line y=3 pixels 0003..000A; sel=3 -> third frame's bytes all 8'h02; after 256 frames the value wraps to 00.
REQ-038 Mid-frame controls: en dropped at clock 50 -> frame completes, frame_done at clock 139, then IDLE with all outputs 0; sel changed mid-frame -> current frame's data unchanged.
REQ-039 Reset mid-frame: rst_n pulsed low during ACTIVE -> outputs 0 within the same clock; with en=1 after release, vsync rises on the first edge.
